onchip_memory_stream_reader: RTL and testbench

ONCHIP_MEMORY_STREAM_READER -- requirements
Module: onchip_memory_stream_reader

---
 rtl/onchip_memory_stream_reader.sv | 198 +++++++++++++++++++
 tb/tb_onchip_memory_stream_reader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_memory_stream_reader.sv
// Streams a contiguous word range out of a 1-cycle-latency on-chip memory.
// A credit check on FIFO occupancy plus reads in flight means read data never finds the FIFO full.
module onchip_memory_stream_reader #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_WORDS  = 51200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_startofpacket,
    output logic              src_endofpacket
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   issue_left_q, issue_left_d;
    logic [ADDR_W-1:0]   wc_q, wc_d;
    logic [ADDR_W-1:0]   beat_q, beat_d;
    logic                err_q, err_d;
    logic                cs_q, cs_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                rd_valid_q;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                valid_q, valid_d;
    logic                sop_q, sop_d;
    logic                eop_q, eop_d;
    logic [DATA_W-1:0]   fifo_q [FIFO_DEPTH];

    logic                push;
    logic                pop;
    logic                credit_ok;
    logic                range_bad;
    logic [ADDR_W:0]     end_addr;

    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    assign mem_address       = mem_addr_q;
    assign mem_chipselect    = cs_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;
    assign src_valid         = valid_q;
    assign src_startofpacket = sop_q;
    assign src_endofpacket   = eop_q;
    assign src_data          = fifo_q[rd_ptr_q];

    // A read visible on the port this cycle (cs_q) or returning this cycle (rd_valid_q) holds a slot.
    assign push      = rd_valid_q;
    assign pop       = valid_q & src_ready;
    assign credit_ok = (SUM_W'(count_q) + SUM_W'(rd_valid_q) + SUM_W'(cs_q)) < SUM_W'(FIFO_DEPTH);
    assign end_addr  = (ADDR_W+1)'(base_addr) + (ADDR_W+1)'(word_count);
    assign range_bad = end_addr > (ADDR_W+1)'(MEM_WORDS);

    assign wr_ptr_d = push ? PTR_W'(wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    assign rd_ptr_d = pop  ? PTR_W'(rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    assign count_d  = CNT_W'(count_q + CNT_W'(push) - CNT_W'(pop));

    // Command sequencing and read issue
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        wc_d         = wc_q;
        beat_d       = pop ? ADDR_W'(beat_q + ADDR_W'(1)) : beat_q;
        err_d        = err_q;
        cs_d         = 1'b0;
        mem_addr_d   = mem_addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d       = base_addr;
                    issue_left_d = word_count;
                    wc_d         = word_count;
                    beat_d       = '0;
                    err_d        = 1'b0;
                    if (word_count == '0) begin
                        state_d = S_FINISH;
                    end else if (range_bad) begin
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (credit_ok) begin
                    cs_d         = 1'b1;
                    mem_addr_d   = addr_q;
                    addr_d       = ADDR_W'(addr_q + ADDR_W'(1));
                    issue_left_d = ADDR_W'(issue_left_q - ADDR_W'(1));
                    if (issue_left_q == ADDR_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!cs_q && !rd_valid_q &&
                    ((count_q == '0) || ((count_q == CNT_W'(1)) && pop))) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_FINISH);
        error_d = (state_d == S_FINISH) && err_d;
        valid_d = (count_d != '0);
        sop_d   = valid_d && (beat_d == '0);
        eop_d   = valid_d && (beat_d == ADDR_W'(wc_d - ADDR_W'(1)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            wc_q         <= '0;
            beat_q       <= '0;
            err_q        <= 1'b0;
            cs_q         <= 1'b0;
            mem_addr_q   <= '0;
            rd_valid_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            valid_q      <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            wc_q         <= wc_d;
            beat_q       <= beat_d;
            err_q        <= err_d;
            cs_q         <= cs_d;
            mem_addr_q   <= mem_addr_d;
            rd_valid_q   <= cs_q;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            valid_q      <= valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= mem_readdata;
        end
    end

endmodule

// File: tb/tb_onchip_memory_stream_reader.sv
// Directed bench for onchip_memory_stream_reader with a mem[k]=k memory model.
module tb_onchip_memory_stream_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, error;
    logic [15:0] mem_address;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata = '0;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_ready = 1'b1;
    logic        src_startofpacket, src_endofpacket;

    int n_vec = 0;
    int n_err = 0;

    onchip_memory_stream_reader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .error(error),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .src_startofpacket(src_startofpacket), .src_endofpacket(src_endofpacket)
    );

    always #5 clk = ~clk;

    // Memory holds mem[k] = k, read latency one cycle
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= 32'(mem_address);
    end

    // Sink readiness: 0 = always ready, 1 = 1-0-0-1 pattern, 2 = never ready
    int       rdy_mode = 0;
    int       phase = 0;
    logic [3:0] pat = 4'b1001;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) src_ready = 1'b1;
            else if (rdy_mode == 2) src_ready = 1'b0;
            else src_ready = pat[phase[1:0]];
            phase = phase + 1;
        end
    end

    // Observation log, sampled on the falling edge
    int          cyc = 0;
    int          n_issue = 0, n_beat = 0, n_done = 0, n_valid = 0;
    int          credit_viol = 0, stall_viol = 0, err_alone = 0;
    int          done_cyc = 0;
    logic        done_err = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] bd_q[$];
    logic        bs_q[$], be_q[$];
    int          bc_q[$];
    logic [15:0] ia_q[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_chipselect) begin
            if (n_issue - n_beat >= 4) credit_viol = credit_viol + 1;
            n_issue = n_issue + 1;
            ia_q.push_back(mem_address);
        end
        if (prev_stall && !(src_valid && src_data == prev_data)) stall_viol = stall_viol + 1;
        prev_stall = src_valid && !src_ready;
        prev_data  = src_data;
        if (src_valid) n_valid = n_valid + 1;
        if (src_valid && src_ready) begin
            n_beat = n_beat + 1;
            bd_q.push_back(src_data);
            bs_q.push_back(src_startofpacket);
            be_q.push_back(src_endofpacket);
            bc_q.push_back(cyc);
        end
        if (done) begin
            n_done   = n_done + 1;
            done_cyc = cyc;
            done_err = error;
        end
        if (error && !done) err_alone = err_alone + 1;
    end

    task automatic clear_logs();
        n_issue = 0; n_beat = 0; n_done = 0; n_valid = 0;
        credit_viol = 0; stall_viol = 0; err_alone = 0;
        bd_q.delete(); bs_q.delete(); be_q.delete(); bc_q.delete(); ia_q.delete();
        phase = 0;
    endtask

    task automatic start_cmd(input logic [15:0] b, input logic [15:0] c);
        @(posedge clk);
        #1;
        base_addr = b; word_count = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0;
        d0 = n_done;
        for (int i = 0; i < 300 && n_done == d0; i++) @(negedge clk);
        n_vec++;
        if (n_done == d0) begin
            n_err++;
            $display("FAIL %s_done_timeout: done seen %0d times, required 1", name, n_done - d0);
        end
    endtask

    task automatic check_stream(input string name, input logic [15:0] b, input int c);
        n_vec++;
        if (n_beat !== c) begin
            n_err++;
            $display("FAIL %s_beats: got %0d required %0d", name, n_beat, c);
        end
        for (int i = 0; i < c && i < n_beat; i++) begin
            n_vec++;
            if (bd_q[i] !== 32'(b) + 32'(i) || bs_q[i] !== (i == 0) || be_q[i] !== (i == c - 1)) begin
                n_err++;
                $display("FAIL %s_beat%0d: got data %h sop %b eop %b required data %h sop %b eop %b",
                         name, i, bd_q[i], bs_q[i], be_q[i], 32'(b) + 32'(i), (i == 0), (i == c - 1));
            end
        end
        n_vec++;
        if (done_err !== 1'b0) begin
            n_err++;
            $display("FAIL %s_error: got %b required 0", name, done_err);
        end
    endtask

    task automatic test_reset();
        logic [25:0] obs;
        reset = 1'b1; start = 1'b1; base_addr = 16'h0010; word_count = 16'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs = {busy, done, error, src_valid, src_startofpacket, src_endofpacket,
               mem_chipselect, mem_write, mem_clken, mem_byteenable, mem_address, 1'b0};
        n_vec++;
        if (obs !== {9'b000000001, 4'hF, 16'h0000, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required %h", obs, {9'b000000001, 4'hF, 16'h0000, 1'b0});
        end
        @(posedge clk);
        #1;
        start = 1'b0; reset = 1'b0;
        clear_logs();
        repeat (5) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || n_issue !== 0 || n_done !== 0) begin
            n_err++;
            $display("FAIL reset_overrides_start: got busy %b issues %0d dones %0d required 0 0 0",
                     busy, n_issue, n_done);
        end
    endtask

    task automatic test_basic();
        rdy_mode = 0;
        clear_logs();
        start_cmd(16'h0010, 16'd8);
        wait_done("basic");
        check_stream("basic", 16'h0010, 8);
        for (int i = 1; i < 8 && i < n_beat; i++) begin
            n_vec++;
            if (bc_q[i] !== bc_q[0] + i) begin
                n_err++;
                $display("FAIL basic_consecutive%0d: got cycle %0d required %0d", i, bc_q[i], bc_q[0] + i);
            end
        end
        n_vec++;
        if (n_beat == 8 && done_cyc !== bc_q[7] + 1) begin
            n_err++;
            $display("FAIL basic_done_timing: got cycle %0d required %0d", done_cyc, bc_q[7] + 1);
        end
        n_vec++;
        if (n_issue !== 8 || (n_issue > 0 && ia_q[0] !== 16'h0010) || (n_issue > 7 && ia_q[7] !== 16'h0017)) begin
            n_err++;
            $display("FAIL basic_issues: got %0d required 8 over 0x10..0x17", n_issue);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_after_done: got busy %b done %b required 0 0", busy, done);
        end
    endtask

    task automatic test_backpressure();
        rdy_mode = 1;
        clear_logs();
        start_cmd(16'h0010, 16'd8);
        wait_done("bp");
        check_stream("bp", 16'h0010, 8);
        n_vec++;
        if (credit_viol !== 0 || stall_viol !== 0) begin
            n_err++;
            $display("FAIL bp_credit_stall: got credit %0d stall %0d required 0 0", credit_viol, stall_viol);
        end
        rdy_mode = 0;
    endtask

    task automatic test_boundary();
        clear_logs();
        start_cmd(16'hC7FF, 16'd1);
        wait_done("edge1");
        check_stream("edge1", 16'hC7FF, 1);
        clear_logs();
        start_cmd(16'hC7FF, 16'd2);
        wait_done("edge2");
        repeat (3) @(negedge clk);
        n_vec++;
        if (done_err !== 1'b1 || err_alone !== 0) begin
            n_err++;
            $display("FAIL edge2_error: got err %b lone %0d required 1 0", done_err, err_alone);
        end
        n_vec++;
        if (n_issue !== 0 || n_beat !== 0) begin
            n_err++;
            $display("FAIL edge2_no_reads: got issues %0d beats %0d required 0 0", n_issue, n_beat);
        end
    endtask

    task automatic test_zero_count();
        clear_logs();
        start_cmd(16'h0005, 16'd0);
        wait_done("zero");
        repeat (3) @(negedge clk);
        n_vec++;
        if (done_err !== 1'b0 || n_issue !== 0 || n_valid !== 0) begin
            n_err++;
            $display("FAIL zero_count: got err %b issues %0d valid %0d required 0 0 0",
                     done_err, n_issue, n_valid);
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        start_cmd(16'h0100, 16'd6);
        start_cmd(16'h0200, 16'd5);
        wait_done("b2b");
        repeat (12) @(negedge clk);
        check_stream("b2b", 16'h0100, 6);
        n_vec++;
        if (n_done !== 1 || n_issue !== 6) begin
            n_err++;
            $display("FAIL b2b_ignored: got dones %0d issues %0d required 1 6", n_done, n_issue);
        end
    endtask

    task automatic test_reset_midrun();
        int seen;
        logic [7:0] obs;
        rdy_mode = 2;
        clear_logs();
        start_cmd(16'h0040, 16'd8);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (mem_chipselect) seen = 1;
        end
        n_vec++;
        if (seen == 0) begin
            n_err++;
            $display("FAIL midrun_issue_timeout: got no read issue, required one");
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        obs = {busy, done, error, src_valid, src_startofpacket, src_endofpacket,
               mem_chipselect, (mem_address != 16'h0)};
        n_vec++;
        if (obs !== 8'h00) begin
            n_err++;
            $display("FAIL midrun_reset_outputs: got %b required 00000000", obs);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        rdy_mode = 0;
        clear_logs();
        repeat (10) @(negedge clk);
        n_vec++;
        if (n_beat !== 0 || n_done !== 0 || n_issue !== 0) begin
            n_err++;
            $display("FAIL midrun_stale: got beats %0d dones %0d issues %0d required 0 0 0",
                     n_beat, n_done, n_issue);
        end
        clear_logs();
        start_cmd(16'h0020, 16'd3);
        wait_done("post_reset");
        check_stream("post_reset", 16'h0020, 3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_boundary();
        test_zero_count();
        test_back_to_back();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
